// File: rtl/merge_4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | merge_4 : four-way merge. A 2-bit control token picks which input supplies  |
// |           the next word. The word passes through a 2-entry output FIFO,    |
// |           and a wrapping transfer counter is kept for each port.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module merge_4 #(
    parameter int W    = 11,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            _RESET,
    input  logic [1:0]      ctrl_data,
    input  logic            ctrl_valid,
    output logic            ctrl_ready,
    input  logic [W-1:0]    in1_data,
    input  logic            in1_valid,
    output logic            in1_ready,
    input  logic [W-1:0]    in2_data,
    input  logic            in2_valid,
    output logic            in2_ready,
    input  logic [W-1:0]    in3_data,
    input  logic            in3_valid,
    output logic            in3_ready,
    input  logic [W-1:0]    in4_data,
    input  logic            in4_valid,
    output logic            in4_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CNTW-1:0] cnt1,
    output logic [CNTW-1:0] cnt2,
    output logic [CNTW-1:0] cnt3,
    output logic [CNTW-1:0] cnt4
);

    typedef enum logic [0:0] {
        S_CTRL = 1'b0,
        S_DATA = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      count_q, count_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic [W-1:0]    mem_q [2];
    logic [W-1:0]    mem_d [2];
    logic [CNTW-1:0] cnt_q [4];
    logic [CNTW-1:0] cnt_d [4];

    logic [3:0]      in_valid;
    logic [3:0]      in_ready;
    logic [W-1:0]    in_data [4];
    logic            push;
    logic            pop;

    assign in_valid   = {in4_valid, in3_valid, in2_valid, in1_valid};
    assign in_data[0] = in1_data;
    assign in_data[1] = in2_data;
    assign in_data[2] = in3_data;
    assign in_data[3] = in4_data;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        in_ready = 4'b0000;

        // Ready is derived from registered state only; no valid feeds back into it.
        if (state_q == S_DATA && count_q != 2'd2) begin
            in_ready[sel_q] = 1'b1;
        end

        push = in_ready[sel_q] && in_valid[sel_q];
        pop  = (count_q != 2'd0) && out_ready;

        case (state_q)
            S_CTRL: begin
                if (ctrl_valid) begin
                    sel_d   = ctrl_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (push) begin
                    state_d = S_CTRL;
                end
            end
            default: state_d = S_CTRL;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = in_data[sel_q];
            wr_ptr_d        = ~wr_ptr_q;
            cnt_d[sel_q]    = cnt_q[sel_q] + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q  <= S_CTRL;
            sel_q    <= 2'd0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ctrl_ready = (state_q == S_CTRL);
    assign in1_ready  = in_ready[0];
    assign in2_ready  = in_ready[1];
    assign in3_ready  = in_ready[2];
    assign in4_ready  = in_ready[3];
    assign out_valid  = (count_q != 2'd0);
    assign out_data   = mem_q[rd_ptr_q];
    assign cnt1       = cnt_q[0];
    assign cnt2       = cnt_q[1];
    assign cnt3       = cnt_q[2];
    assign cnt4       = cnt_q[3];

endmodule
`default_nettype wire
